// File: rtl/gon_pkg.sv
// Shared types and widths for the global output network collector.
package gon_pkg;

    localparam int unsigned ROW_TAG_WIDTH = 4;
    localparam int unsigned COL_TAG_WIDTH = 4;
    localparam int unsigned TAG_WIDTH     = ROW_TAG_WIDTH + COL_TAG_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } gon_state_t;

    typedef struct packed {
        logic [COL_TAG_WIDTH-1:0] col;
        logic [ROW_TAG_WIDTH-1:0] row;
    } tag_t;

endpackage

// File: rtl/gon_sync_fifo.sv
// Single-clock FIFO with full/empty flags and a registered read port.
module gon_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr_c;
    logic             do_rd_c;

    // Extra pointer bit distinguishes full from empty when addresses match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign do_wr_c = wr_en && !full;
    assign do_rd_c = rd_en && !empty;
    assign rd_data = rd_data_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (do_wr_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd_c) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            rd_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/gon_collector.sv
// Global output network collector: pops (row,col) read orders, handshakes one
// word out of the addressed PE per order, and queues it for the host.
module gon_collector
    import gon_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 64,
    parameter int unsigned NUM_OF_ROWS         = 12,
    parameter int unsigned NUM_OF_COLS         = 14,
    parameter int unsigned GON_TAGS_FIFO_DEPTH = 16,
    parameter int unsigned GON_DATA_FIFO_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ROW_TAG_WIDTH-1:0] row_tag,
    input  logic [COL_TAG_WIDTH-1:0] col_tag,
    input  logic                     tags_wr_en,
    output logic                     tags_full,
    input  logic [0:NUM_OF_COLS-1]   enable_in [NUM_OF_ROWS],
    input  logic [DATA_WIDTH-1:0]    data_in [NUM_OF_ROWS][NUM_OF_COLS],
    output logic [0:NUM_OF_COLS-1]   ready_out [NUM_OF_ROWS],
    input  logic                     data_rd_en,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_empty,
    output logic                     data_full,
    output logic                     tag_err
);

    gon_state_t               state_q, state_d;
    logic [ROW_TAG_WIDTH-1:0] cur_row_q, cur_row_d;
    logic [COL_TAG_WIDTH-1:0] cur_col_q, cur_col_d;
    logic                     tag_err_q, tag_err_d;

    tag_t                     tag_wr_c;
    tag_t                     tag_rd;
    logic                     tag_empty;
    logic                     tag_rd_en_c;
    logic                     data_wr_en_c;
    logic                     handshake_c;
    logic [DATA_WIDTH-1:0]    sel_data_c;

    assign tag_wr_c = '{col: col_tag, row: row_tag};
    assign tag_err  = tag_err_q;

    gon_sync_fifo #(
        .WIDTH (TAG_WIDTH),
        .DEPTH (GON_TAGS_FIFO_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tags_wr_en),
        .wr_data (tag_wr_c),
        .rd_en   (tag_rd_en_c),
        .rd_data (tag_rd),
        .full    (tags_full),
        .empty   (tag_empty)
    );

    gon_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (GON_DATA_FIFO_DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (data_wr_en_c),
        .wr_data (sel_data_c),
        .rd_en   (data_rd_en),
        .rd_data (data_out),
        .full    (data_full),
        .empty   (data_empty)
    );

    // Ready one-hot, handshake detect and data mux for the PE being serviced.
    always_comb begin
        handshake_c = 1'b0;
        sel_data_c  = '0;
        for (int unsigned r = 0; r < NUM_OF_ROWS; r++) begin
            for (int unsigned c = 0; c < NUM_OF_COLS; c++) begin
                ready_out[r][c] = 1'b0;
                if ((state_q == WAIT) &&
                    (cur_row_q == ROW_TAG_WIDTH'(r)) &&
                    (cur_col_q == COL_TAG_WIDTH'(c))) begin
                    ready_out[r][c] = !data_full;
                    handshake_c     = enable_in[r][c] && !data_full;
                    sel_data_c      = data_in[r][c];
                end
            end
        end
    end

    // Sequencer: one tag in flight, next tag popped on the handshake edge.
    always_comb begin
        state_d      = state_q;
        cur_row_d    = cur_row_q;
        cur_col_d    = cur_col_q;
        tag_err_d    = tag_err_q;
        tag_rd_en_c  = 1'b0;
        data_wr_en_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!tag_empty) begin
                    tag_rd_en_c = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                cur_row_d = tag_rd.row;
                cur_col_d = tag_rd.col;
                if ((32'(tag_rd.row) >= NUM_OF_ROWS) || (32'(tag_rd.col) >= NUM_OF_COLS)) begin
                    tag_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (handshake_c) begin
                    data_wr_en_c = 1'b1;
                    if (!tag_empty) begin
                        tag_rd_en_c = 1'b1;
                        state_d     = LOAD;
                    end else begin
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_row_q <= '0;
            cur_col_q <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            tag_err_q <= tag_err_d;
        end
    end

endmodule

// File: tb/tb_gon_collector.sv
// Bench for gon_collector: queue-based reference of read orders and output
// words checked every cycle, plus directed timing scenarios with literal values.
module tb_gon_collector;

    localparam int NR     = 12;
    localparam int NC     = 14;
    localparam int DW     = 64;
    localparam int DDEPTH = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      row_tag;
    logic [3:0]      col_tag;
    logic            tags_wr_en;
    logic            tags_full;
    logic [0:NC-1]   en [NR];
    logic [DW-1:0]   dval [NR][NC];
    logic [0:NC-1]   ready_out [NR];
    logic            data_rd_en;
    logic [DW-1:0]   data_out;
    logic            data_empty;
    logic            data_full;
    logic            tag_err;

    gon_collector dut (
        .clk        (clk),
        .reset      (reset),
        .row_tag    (row_tag),
        .col_tag    (col_tag),
        .tags_wr_en (tags_wr_en),
        .tags_full  (tags_full),
        .enable_in  (en),
        .data_in    (dval),
        .ready_out  (ready_out),
        .data_rd_en (data_rd_en),
        .data_out   (data_out),
        .data_empty (data_empty),
        .data_full  (data_full),
        .tag_err    (tag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
    } mtag_t;

    mtag_t         tq[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_dout;
    bit            seen_bad;
    int            hs_cyc[$];
    int            cyc;
    int            n_checks;
    int            n_fail;
    logic [DW-1:0] t2_exp [3];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] sel_code(input int n, input int r, input int c);
        return (64'(n) << 16) | (64'(r) << 8) | 64'(c);
    endfunction

    function automatic int head_idx();
        for (int i = 0; i < tq.size(); i++) begin
            if (tq[i].r < NR && tq[i].c < NC) return i;
        end
        return -1;
    endfunction

    function automatic int rdy_count();
        int n = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (ready_out[r][c]) n++;
        return n;
    endfunction

    // Reference: tags queue in order, each valid tag yields one word from its PE.
    always @(negedge clk) begin
        int rc;
        int rr;
        int rcol;
        int hidx;
        logic [63:0] exp_sel;
        if (reset) begin
            tq.delete();
            mq.delete();
            seen_bad = 1'b0;
            exp_dout = '0;
        end
        rc = 0;
        rr = 0;
        rcol = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (ready_out[r][c]) begin
                    rc++;
                    rr = r;
                    rcol = c;
                end
        hidx = head_idx();
        if (rc != 0) begin
            exp_sel = 64'd0;
            if (hidx >= 0 && mq.size() < DDEPTH) exp_sel = sel_code(1, tq[hidx].r, tq[hidx].c);
            check("ready_sel", sel_code(rc, rr, rcol), exp_sel);
        end
        check("data_empty", 64'(data_empty), 64'(mq.size() == 0));
        check("data_full", 64'(data_full), 64'(mq.size() == DDEPTH));
        check("data_out", data_out, exp_dout);
        if (!seen_bad) check("tag_err_early", 64'(tag_err), 64'd0);
        if (!reset) begin
            if (data_rd_en && mq.size() > 0) exp_dout = mq.pop_front();
            if (rc == 1 && en[rr][rcol]) begin
                hs_cyc.push_back(cyc);
                mq.push_back(dval[rr][rcol]);
                for (int k = 0; k <= hidx; k++) void'(tq.pop_front());
            end
            if (tags_wr_en && !tags_full) begin
                tq.push_back('{int'(row_tag), int'(col_tag)});
                if (int'(row_tag) >= NR || int'(col_tag) >= NC) seen_bad = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic set_all_en(input logic v);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                en[r][c] = v;
    endtask

    task automatic push_tag(input int r, input int c);
        row_tag = 4'(r);
        col_tag = 4'(c);
        tags_wr_en = 1'b1;
        tick();
        tags_wr_en = 1'b0;
    endtask

    task automatic drain_one();
        tick();
        data_rd_en = 1'b1;
        tick();
        data_rd_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        t2_exp[0] = 64'h00;
        t2_exp[1] = 64'hBD;
        t2_exp[2] = 64'h37;
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        row_tag = '0;
        col_tag = '0;
        tags_wr_en = 1'b0;
        data_rd_en = 1'b0;
        set_all_en(1'b0);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                dval[r][c] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(rdy_count()), 64'd0);
        check("rst_tags_full", 64'(tags_full), 64'd0);
        check("rst_data_empty", 64'(data_empty), 64'd1);
        check("rst_data_out", data_out, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // T1: single tag (2,5), minimum latency
        en[2][5] = 1'b1;
        dval[2][5] = 64'hA5;
        row_tag = 4'd2;
        col_tag = 4'd5;
        tags_wr_en = 1'b1;
        @(negedge clk);
        tick();
        tags_wr_en = 1'b0;
        @(negedge clk);
        tick(); @(negedge clk);
        check("t1_rdy_c2", 64'(ready_out[2][5]), 64'd0);
        tick(); @(negedge clk);
        check("t1_rdy_c3", 64'(ready_out[2][5]), 64'd1);
        check("t1_rdy_cnt", 64'(rdy_count()), 64'd1);
        check("t1_empty_c3", 64'(data_empty), 64'd1);
        tick(); @(negedge clk);
        check("t1_empty_c4", 64'(data_empty), 64'd0);
        drain_one();
        check("t1_dout", data_out, 64'hA5);

        // T2: three queued tags, steady-state rate
        tick();
        set_all_en(1'b1);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                dval[r][c] = 64'(r * 16 + c);
        hs_cyc.delete();
        push_tag(0, 0);
        push_tag(11, 13);
        push_tag(3, 7);
        wait_cyc(12);
        @(negedge clk);
        check("t2_hs_count", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) begin
            check("t2_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd2);
            check("t2_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd2);
        end
        tick();
        data_rd_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) data_rd_en = 1'b0;
            @(negedge clk);
            check("t2_order", data_out, t2_exp[i]);
        end

        // T3: addressed PE late, neighbour valid throughout
        tick();
        set_all_en(1'b0);
        en[1][2] = 1'b1;
        dval[1][1] = 64'h11;
        dval[1][2] = 64'h12;
        row_tag = 4'd1;
        col_tag = 4'd1;
        tags_wr_en = 1'b1;
        @(negedge clk);
        for (int j = 1; j <= 21; j++) begin
            tick();
            if (j == 1) tags_wr_en = 1'b0;
            if (j == 20) en[1][1] = 1'b1;
            @(negedge clk);
            if (j == 19) begin
                check("t3_rdy11", 64'(ready_out[1][1]), 64'd1);
                check("t3_rdy12", 64'(ready_out[1][2]), 64'd0);
                check("t3_empty_c19", 64'(data_empty), 64'd1);
            end
            if (j == 21) check("t3_empty_c21", 64'(data_empty), 64'd0);
        end
        drain_one();
        check("t3_dout", data_out, 64'h11);

        // T4: output FIFO full backpressure
        tick();
        set_all_en(1'b1);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                dval[r][c] = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) push_tag(int'($urandom % NR), int'($urandom % NC));
        wait_cyc(40);
        @(negedge clk);
        check("t4_full", 64'(data_full), 64'd1);
        tick();
        dval[5][6] = 64'hBEEF;
        push_tag(5, 6);
        wait_cyc(10);
        @(negedge clk);
        check("t4_rdy_blocked", 64'(rdy_count()), 64'd0);
        check("t4_still_full", 64'(data_full), 64'd1);
        drain_one();
        wait_cyc(5);
        @(negedge clk);
        check("t4_full_again", 64'(data_full), 64'd1);
        tick();
        data_rd_en = 1'b1;
        wait_cyc(16);
        data_rd_en = 1'b0;
        @(negedge clk);
        check("t4_last_word", data_out, 64'hBEEF);
        check("t4_empty", 64'(data_empty), 64'd1);

        // T5: out-of-range tag then a valid one
        tick();
        dval[0][1] = 64'h77;
        push_tag(12, 0);
        push_tag(0, 1);
        wait_cyc(10);
        @(negedge clk);
        check("t5_tag_err", 64'(tag_err), 64'd1);
        check("t5_empty", 64'(data_empty), 64'd0);
        drain_one();
        check("t5_dout", data_out, 64'h77);
        check("t5_err_sticky", 64'(tag_err), 64'd1);

        // Randomized traffic against the reference
        for (int it = 0; it < 3000; it++) begin
            int rr;
            int rcc;
            tick();
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++)
                    en[r][c] = ($urandom % 3) != 0;
            if ($urandom % 8 == 0) begin
                rr = int'($urandom % NR);
                rcc = int'($urandom % NC);
                dval[rr][rcc] = {$urandom, $urandom};
            end
            tags_wr_en = ($urandom % 3) == 0;
            row_tag = ($urandom % 25 == 0) ? 4'(12 + $urandom % 4) : 4'($urandom % NR);
            col_tag = ($urandom % 25 == 0) ? 4'(14 + $urandom % 2) : 4'($urandom % NC);
            data_rd_en = ((it % 600) < 300) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
        end
        tick();
        tags_wr_en = 1'b0;
        set_all_en(1'b1);
        data_rd_en = 1'b1;
        k = 0;
        while ((head_idx() >= 0 || mq.size() > 0) && k < 400) begin
            tick();
            k++;
        end
        check("rand_quiesce", 64'(k < 400), 64'd1);
        wait_cyc(6);
        data_rd_en = 1'b0;
        @(negedge clk);
        check("rand_tag_err", 64'(tag_err), 64'(seen_bad));
        check("rand_empty", 64'(data_empty), 64'd1);

        // T6: reset while waiting with the tag FIFO full
        tick();
        set_all_en(1'b0);
        for (int i = 0; i < 17; i++) begin
            row_tag = 4'(i % NR);
            col_tag = 4'(i % NC);
            tags_wr_en = 1'b1;
            tick();
        end
        tags_wr_en = 1'b0;
        @(negedge clk);
        check("t6_tags_full", 64'(tags_full), 64'd1);
        check("t6_rdy00", 64'(ready_out[0][0]), 64'd1);
        tick();
        push_tag(7, 7);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", 64'(rdy_count()), 64'd0);
        check("t6_rst_tags_full", 64'(tags_full), 64'd0);
        check("t6_rst_empty", 64'(data_empty), 64'd1);
        check("t6_rst_tag_err", 64'(tag_err), 64'd0);
        check("t6_rst_dout", data_out, 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_post_ready", 64'(rdy_count()), 64'd0);
        check("t6_post_err", 64'(tag_err), 64'd0);
        tick();
        set_all_en(1'b1);
        dval[4][4] = 64'hC0FFEE;
        push_tag(4, 4);
        wait_cyc(8);
        @(negedge clk);
        check("t6_new_word", 64'(data_empty), 64'd0);
        drain_one();
        check("t6_dout", data_out, 64'hC0FFEE);
        check("t6_drained", 64'(data_empty), 64'd1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
